// File: rtl/d_format_pkg.sv
// Shared constants and state type for the uPOWER D-format sequencer.
package d_format_pkg;
    localparam logic [5:0] OP_ADDI  = 6'd14;
    localparam logic [5:0] OP_ADDIS = 6'd15;
    localparam logic [5:0] OP_ORI   = 6'd24;
    localparam logic [5:0] OP_XORI  = 6'd26;
    localparam logic [5:0] OP_ANDI  = 6'd28;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_e;
endpackage

// File: rtl/d_format_decode.sv
// Combinational D-format decode: primary opcode and SI to {legal, ALU code, immediate}.
module d_format_decode
    import d_format_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [5:0]      po,
    input  logic [15:0]     si,
    output logic            legal,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] imm
);
    logic [XLEN-1:0] sext_si, sext_hi, zext_si;

    assign sext_si = {{(XLEN-16){si[15]}}, si};
    assign sext_hi = {{(XLEN-32){si[15]}}, si, 16'h0000};
    assign zext_si = {{(XLEN-16){1'b0}}, si};

    always_comb begin
        legal  = 1'b1;
        alu_op = ALU_AND;
        imm    = '0;
        case (po)
            OP_ADDI:  begin alu_op = ALU_ADD; imm = sext_si; end
            OP_ADDIS: begin alu_op = ALU_ADD; imm = sext_hi; end
            OP_ORI:   begin alu_op = ALU_OR;  imm = zext_si; end
            OP_XORI:  begin alu_op = ALU_XOR; imm = zext_si; end
            OP_ANDI:  begin alu_op = ALU_AND; imm = zext_si; end
            default:  legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/d_format_seq.sv
// Four-state D-format sequencer: accept, decode, execute, write back; counts retired/illegal.
// Optional macro D_FORMAT_RA0_EN enables (RA|0) handling for addi/addis via ra_zero.
module d_format_seq
    import d_format_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [4:0]       rf_ra_addr,
    output logic [4:0]       rf_rt_addr,
    output logic             rf_we,
    output logic [XLEN-1:0]  imm,
    output logic [3:0]       alu_op,
    output logic             ra_zero,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);
    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [4:0]        ra_addr_q, ra_addr_d, rt_addr_q, rt_addr_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d, illegal_cnt_q, illegal_cnt_d;

    logic              dec_legal;
    logic [3:0]        dec_alu_op;
    logic [XLEN-1:0]   dec_imm;

    d_format_decode #(.XLEN(XLEN)) u_decode (
        .po     (instr_q[31:26]),
        .si     (instr_q[15:0]),
        .legal  (dec_legal),
        .alu_op (dec_alu_op),
        .imm    (dec_imm)
    );

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        retired_cnt_d = retired_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        instr_ready   = 1'b0;
        rf_we         = 1'b0;
        done          = 1'b0;
        illegal       = 1'b0;

        // In flight the fields come straight from the captured word; IDLE replays the last ones.
        if (state_q == IDLE) begin
            rf_ra_addr = ra_addr_q;
            rf_rt_addr = rt_addr_q;
        end else begin
            rf_ra_addr = instr_q[20:16];
            rf_rt_addr = instr_q[25:21];
        end
        if (state_q != IDLE && dec_legal) begin
            imm    = dec_imm;
            alu_op = dec_alu_op;
        end else begin
            imm    = imm_q;
            alu_op = alu_op_q;
        end
        ra_addr_d = rf_ra_addr;
        rt_addr_d = rf_rt_addr;
        imm_d     = imm;
        alu_op_d  = alu_op;

        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_legal) begin
                    state_d = EXEC;
                end else begin
                    done          = 1'b1;
                    illegal       = 1'b1;
                    illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
                    state_d       = IDLE;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                rf_we         = 1'b1;
                done          = 1'b1;
                retired_cnt_d = retired_cnt_q + CNT_W'(1);
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset kills the strobes in the same cycle so an aborted op never writes.
        if (rst) begin
            rf_we   = 1'b0;
            done    = 1'b0;
            illegal = 1'b0;
        end

`ifdef D_FORMAT_RA0_EN
        ra_zero = (state_q != IDLE) && (instr_q[20:16] == 5'd0) &&
                  ((instr_q[31:26] == OP_ADDI) || (instr_q[31:26] == OP_ADDIS));
`else
        ra_zero = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            ra_addr_q     <= '0;
            rt_addr_q     <= '0;
            imm_q         <= '0;
            alu_op_q      <= '0;
            retired_cnt_q <= '0;
            illegal_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            ra_addr_q     <= ra_addr_d;
            rt_addr_q     <= rt_addr_d;
            imm_q         <= imm_d;
            alu_op_q      <= alu_op_d;
            retired_cnt_q <= retired_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
endmodule

// File: tb/tb_d_format_seq.sv
// Directed table-driven bench for d_format_seq (CNT_W=4 so counter wrap is reachable).
module tb_d_format_seq;
    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic [4:0]       rf_ra_addr, rf_rt_addr;
    logic             rf_we;
    logic [XLEN-1:0]  imm;
    logic [3:0]       alu_op;
    logic             ra_zero;
    logic             done;
    logic             illegal;
    logic [CNT_W-1:0] retired_cnt, illegal_cnt;

    d_format_seq #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_ra_addr  (rf_ra_addr),
        .rf_rt_addr  (rf_rt_addr),
        .rf_we       (rf_we),
        .imm         (imm),
        .alu_op      (alu_op),
        .ra_zero     (ra_zero),
        .done        (done),
        .illegal     (illegal),
        .retired_cnt (retired_cnt),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        legal;
        logic [3:0]  op;
        logic [63:0] imm;
    } vec_t;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [3:0] exp_ret  = '0;
    logic [3:0] exp_ill  = '0;
    logic [63:0] hold_imm = '0;
    logic [3:0]  hold_op  = '0;
    vec_t       tbl[10];

    function automatic logic [31:0] mk(input int po, input int rt, input int ra, input int si);
        logic [31:0] w;
        w = {po[5:0], rt[4:0], ra[4:0], si[15:0]};
        return w;
    endfunction

    function automatic vec_t vv(input logic [31:0] w, input logic lg, input logic [3:0] op,
                                input logic [63:0] im);
        vec_t v;
        v.instr = w; v.legal = lg; v.op = op; v.imm = im;
        return v;
    endfunction

    function automatic logic exp_rz(input logic [31:0] w);
`ifdef D_FORMAT_RA0_EN
        return (w[20:16] == 5'd0) && (w[31:26] == 6'd14 || w[31:26] == 6'd15);
`else
        return 1'b0 & w[0];
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the sequencer expected in IDLE.
    task automatic run_instr(input vec_t v);
        int w;
        w = 0;
        while (!instr_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_offer", instr_ready, 1);
        instr_valid = 1'b1;
        instr       = v.instr;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = $urandom;
        chk("dec_ready", instr_ready, 0);
        chk("dec_ra", rf_ra_addr, v.instr[20:16]);
        chk("dec_rt", rf_rt_addr, v.instr[25:21]);
        chk("dec_done", done, !v.legal);
        chk("dec_illegal", illegal, !v.legal);
        chk("dec_we", rf_we, 0);
        if (!v.legal) begin
            exp_ill = exp_ill + 4'd1;
            @(negedge clk);
            chk("ill_ready_after", instr_ready, 1);
            chk("ill_done_after", done, 0);
            chk("ill_cnt", illegal_cnt, exp_ill);
            chk("ill_ret_cnt", retired_cnt, exp_ret);
            chk("ill_imm_hold", imm, hold_imm);
        end else begin
            chk("dec_op", alu_op, v.op);
            chk("dec_imm", imm, v.imm);
            chk("dec_rz", ra_zero, exp_rz(v.instr));
            @(negedge clk);
            chk("exec_we", rf_we, 0);
            chk("exec_done", done, 0);
            chk("exec_imm", imm, v.imm);
            chk("exec_op", alu_op, v.op);
            @(negedge clk);
            chk("wb_we", rf_we, 1);
            chk("wb_done", done, 1);
            chk("wb_illegal", illegal, 0);
            chk("wb_rt", rf_rt_addr, v.instr[25:21]);
            chk("wb_rz", ra_zero, exp_rz(v.instr));
            exp_ret  = exp_ret + 4'd1;
            hold_imm = v.imm;
            hold_op  = v.op;
            @(negedge clk);
            chk("idle_ready", instr_ready, 1);
            chk("idle_we", rf_we, 0);
            chk("idle_done", done, 0);
            chk("idle_ret_cnt", retired_cnt, exp_ret);
            chk("idle_imm_hold", imm, hold_imm);
            chk("idle_op_hold", alu_op, hold_op);
            chk("idle_rt_hold", rf_rt_addr, v.instr[25:21]);
            chk("idle_rz", ra_zero, 0);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", instr_ready, 1);
        chk("rst_we", rf_we, 0);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_imm", imm, 0);
        chk("rst_ra", rf_ra_addr, 0);
        chk("rst_rt", rf_rt_addr, 0);
        chk("rst_rz", ra_zero, 0);
        chk("rst_ret_cnt", retired_cnt, 0);
        chk("rst_ill_cnt", illegal_cnt, 0);
    endtask

    initial begin
        tbl[0] = vv(mk(14, 3, 1, 16'hFFFF), 1, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF);
        tbl[1] = vv(mk(24, 5, 2, 16'h8000), 1, 4'b0001, 64'h0000_0000_0000_8000);
        tbl[2] = vv(mk(26, 6, 7, 16'h1234), 1, 4'b0011, 64'h0000_0000_0000_1234);
        tbl[3] = vv(mk(28, 8, 9, 16'hF00F), 1, 4'b0000, 64'h0000_0000_0000_F00F);
        tbl[4] = vv(mk(15, 10, 11, 16'h8000), 1, 4'b0010, 64'hFFFF_FFFF_8000_0000);
        tbl[5] = vv(mk(14, 12, 13, 16'h7FFF), 1, 4'b0010, 64'h0000_0000_0000_7FFF);
        tbl[6] = vv(mk(31, 14, 15, 16'h0001), 0, 4'b0000, 64'h0);
        tbl[7] = vv(mk(0, 16, 17, 16'h00FF), 0, 4'b0000, 64'h0);
        tbl[8] = vv(mk(14, 0, 0, 16'h0001), 1, 4'b0010, 64'h0000_0000_0000_0001);
        tbl[9] = vv(mk(15, 4, 0, 16'h0001), 1, 4'b0010, 64'h0000_0000_0001_0000);

        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        @(negedge clk); @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_instr(tbl[i]);

        // Back-to-back offers: second held by not-ready until the first retires.
        instr_valid = 1'b1; instr = mk(15, 7, 4, 16'h0001);
        @(negedge clk);
        instr = mk(24, 9, 6, 16'h8000);
        chk("b2b_dec_ready", instr_ready, 0);
        chk("b2b_dec_imm", imm, 64'h10000);
        @(negedge clk);
        chk("b2b_exec_ready", instr_ready, 0);
        chk("b2b_exec_rt", rf_rt_addr, 7);
        @(negedge clk);
        chk("b2b_wb_ready", instr_ready, 0);
        chk("b2b_wb_we", rf_we, 1);
        chk("b2b_wb_imm", imm, 64'h10000);
        exp_ret = exp_ret + 4'd1;
        @(negedge clk);
        chk("b2b_idle_ready", instr_ready, 1);
        chk("b2b_idle_rt", rf_rt_addr, 7);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("b2b2_dec_ready", instr_ready, 0);
        chk("b2b2_dec_rt", rf_rt_addr, 9);
        chk("b2b2_dec_imm", imm, 64'h8000);
        chk("b2b2_dec_op", alu_op, 4'b0001);
        @(negedge clk);
        chk("b2b2_exec_we", rf_we, 0);
        @(negedge clk);
        chk("b2b2_wb_we", rf_we, 1);
        exp_ret = exp_ret + 4'd1;
        @(negedge clk);
        chk("b2b2_ret_cnt", retired_cnt, exp_ret);

        // Reset while in EXEC: strobes die immediately, everything returns to reset values.
        instr_valid = 1'b1; instr = mk(14, 3, 1, 16'hFFFF);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_we", rf_we, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_vals();
        exp_ret = '0; exp_ill = '0; hold_imm = '0; hold_op = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_abort_we", rf_we, 0);
            chk("post_abort_done", done, 0);
        end

        // Counter wrap: 15 retirements reach 15, the 16th wraps to 0.
        for (int i = 0; i < 15; i++) run_instr(tbl[5]);
        chk("wrap_15", retired_cnt, 15);
        run_instr(tbl[1]);
        chk("wrap_16", retired_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end
endmodule
